// File: rtl/lanzones_mem_arbiter_if.sv
// Bus bundle between the lanzones fetch/load-store requesters, the arbiter and the memory model.
// The master modport is the arbiter side; slave is the requesters plus memory.
interface lanzones_mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IGnt;
  logic          IVld;
  logic [DW-1:0] IData;
  logic          IErr;

  logic          DReq;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData;
  logic          DWEn;
  logic          DGnt;
  logic          DVld;
  logic [DW-1:0] DData;
  logic          DErr;

  logic          RRdy;
  logic [AW-1:0] RAddr;
  logic [DW-1:0] RWData;
  logic          RWEn;
  logic          RVld;
  logic [DW-1:0] RData;

  logic          Busy;

  modport master (
    input  IReq, IAddr, DReq, DAddr, DWData, DWEn, RVld, RData,
    output IGnt, IVld, IData, IErr, DGnt, DVld, DData, DErr,
    output RRdy, RAddr, RWData, RWEn, Busy
  );

  modport slave (
    output IReq, IAddr, DReq, DAddr, DWData, DWEn, RVld, RData,
    input  IGnt, IVld, IData, IErr, DGnt, DVld, DData, DErr,
    input  RRdy, RAddr, RWData, RWEn, Busy
  );
endinterface

// File: rtl/lanzones_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and load/store (D),
// one transaction in flight, with a watchdog that aborts accesses hung in WAIT.
module lanzones_mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  lanzones_mem_arbiter_if.master bus
);

  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state;
  logic           owner_d;
  logic           ptr_d;
  logic           wen_q;
  logic [WDW-1:0] wdog;

  logic           ignt, ivld, ierr, dgnt, dvld, derr;
  logic [DW-1:0]  idata, ddata;
  logic           rrdy, rwen, busy;
  logic [AW-1:0]  raddr;
  logic [DW-1:0]  rwdata;

  logic           pick_d_c;
  logic           both_c;
  logic [WDW-1:0] wdog_nxt_c;
  logic           expire_c;

  // Winner selection and watchdog look-ahead
  always_comb begin
    both_c     = bus.IReq & bus.DReq;
    pick_d_c   = bus.DReq & (~bus.IReq | ptr_d);
    wdog_nxt_c = (&wdog) ? wdog : wdog + WDW'(1);
    expire_c   = (TIMEOUT != 0) && (wdog_nxt_c == WDW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      ptr_d   <= 1'b1;
      wen_q   <= 1'b0;
      wdog    <= '0;
      ignt    <= 1'b0;
      ivld    <= 1'b0;
      ierr    <= 1'b0;
      idata   <= '0;
      dgnt    <= 1'b0;
      dvld    <= 1'b0;
      derr    <= 1'b0;
      ddata   <= '0;
      rrdy    <= 1'b0;
      rwen    <= 1'b0;
      raddr   <= '0;
      rwdata  <= '0;
      busy    <= 1'b0;
    end else begin
      ignt  <= 1'b0;
      ivld  <= 1'b0;
      ierr  <= 1'b0;
      idata <= '0;
      dgnt  <= 1'b0;
      dvld  <= 1'b0;
      derr  <= 1'b0;
      ddata <= '0;
      rrdy  <= 1'b0;
      rwen  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.IReq | bus.DReq) begin
            owner_d <= pick_d_c;
            wen_q   <= pick_d_c & bus.DWEn;
            raddr   <= pick_d_c ? bus.DAddr : bus.IAddr;
            rwdata  <= pick_d_c ? bus.DWData : '0;
            ignt    <= ~pick_d_c;
            dgnt    <= pick_d_c;
            rrdy    <= 1'b1;
            rwen    <= pick_d_c & bus.DWEn;
            // Only a contested slot moves the pointer, towards the loser
            if (both_c) ptr_d <= ~pick_d_c;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end

        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // A response on the expiry edge still counts as a good completion
          if (bus.RVld) begin
            if (owner_d) begin
              dvld  <= 1'b1;
              ddata <= wen_q ? '0 : bus.RData;
            end else begin
              ivld  <= 1'b1;
              idata <= bus.RData;
            end
            wdog  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (expire_c) begin
            dvld  <= owner_d;
            derr  <= owner_d;
            ivld  <= ~owner_d;
            ierr  <= ~owner_d;
            wdog  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog  <= wdog_nxt_c;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.IGnt   = ignt;
  assign bus.IVld   = ivld;
  assign bus.IData  = idata;
  assign bus.IErr   = ierr;
  assign bus.DGnt   = dgnt;
  assign bus.DVld   = dvld;
  assign bus.DData  = ddata;
  assign bus.DErr   = derr;
  assign bus.RRdy   = rrdy;
  assign bus.RAddr  = raddr;
  assign bus.RWData = rwdata;
  assign bus.RWEn   = rwen;
  assign bus.Busy   = busy;

endmodule

// File: tb/tb_lanzones_mem_arbiter.sv
// Directed bench for lanzones_mem_arbiter: single-cycle-response memory model,
// hand-computed grant/response cycle positions, data, watchdog and reset cases.
module tb_lanzones_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic rstn;

  lanzones_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  lanzones_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers one cycle after RRdy unless responses are suppressed
  logic [31:0] mem [0:1023];
  logic        m_rvld;
  logic [31:0] m_rdata;
  logic        force_nvld;
  logic        inj_rvld;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_rvld      <= 1'b0;
      m_rdata     <= '0;
      mem[10'h100] <= 32'hDEADBEEF;
    end else begin
      m_rvld  <= bus.RRdy & ~force_nvld;
      m_rdata <= (bus.RRdy & ~bus.RWEn) ? mem[bus.RAddr[9:0]] : '0;
      if (bus.RRdy & bus.RWEn) mem[bus.RAddr[9:0]] <= bus.RWData;
    end
  end

  assign bus.RVld  = m_rvld | inj_rvld;
  assign bus.RData = m_rdata;

  int n_cmp;
  int n_err;
  int both_cnt;

  always @(negedge clk)
    if ((bus.IGnt & bus.DGnt) | (bus.IVld & bus.DVld) | (bus.IErr & bus.DErr)) both_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction; k counts negedges after the request is raised (accept edge = 1)
  int          t_gnt, t_vld, t_other;
  logic [31:0] t_data;
  logic        t_err, t_rrdy_at_gnt;

  task automatic run_txn(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit wen, input int budget);
    bit done;
    done    = 1'b0;
    t_gnt   = -1;
    t_vld   = -1;
    t_other = 0;
    t_data  = '0;
    t_err   = 1'b0;
    t_rrdy_at_gnt = 1'b0;
    if (is_d) begin
      bus.DReq = 1'b1; bus.DAddr = addr; bus.DWData = wdata; bus.DWEn = wen;
    end else begin
      bus.IReq = 1'b1; bus.IAddr = addr;
    end
    for (int k = 1; k <= budget && !done; k++) begin
      @(negedge clk);
      if (is_d ? bus.DGnt : bus.IGnt) begin
        t_gnt = k;
        t_rrdy_at_gnt = bus.RRdy;
        bus.IReq = 1'b0;
        bus.DReq = 1'b0;
      end
      if (is_d ? (bus.IGnt | bus.IVld) : (bus.DGnt | bus.DVld)) t_other++;
      if (is_d ? bus.DVld : bus.IVld) begin
        t_vld  = k;
        t_data = is_d ? bus.DData : bus.IData;
        t_err  = is_d ? bus.DErr : bus.IErr;
        done   = 1'b1;
      end
    end
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    if (!done) check("txn_timeout", 64'(t_vld), 64'(budget));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  int gseq [4];
  int gk   [4];
  int vk   [4];
  int ng, nv, quiet;

  initial begin
    n_cmp = 0; n_err = 0; both_cnt = 0;
    rstn = 1'b0;
    force_nvld = 1'b0; inj_rvld = 1'b0;
    bus.IReq = 1'b0; bus.IAddr = '0;
    bus.DReq = 1'b0; bus.DAddr = '0; bus.DWData = '0; bus.DWEn = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_outs", 64'({bus.IGnt, bus.IVld, bus.IErr, bus.DGnt, bus.DVld, bus.DErr,
                           bus.RRdy, bus.RWEn, bus.Busy}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: fetch from 0x100
    run_txn(1'b0, 32'h100, 32'h0, 1'b0, 10);
    check("t1_gnt_cyc",  64'(t_gnt), 64'd1);
    check("t1_rrdy",     64'(t_rrdy_at_gnt), 64'd1);
    check("t1_vld_cyc",  64'(t_vld), 64'd3);
    check("t1_idata",    64'(t_data), 64'hDEADBEEF);
    check("t1_ierr",     64'(t_err), 64'd0);
    check("t1_no_d",     64'(t_other), 64'd0);
    @(negedge clk);
    check("t1_idata_clr", 64'(bus.IData), 64'd0);

    // 2: store then load back
    run_txn(1'b1, 32'h104, 32'h12345678, 1'b1, 10);
    check("t2_st_vld_cyc", 64'(t_vld), 64'd3);
    check("t2_st_ddata",   64'(t_data), 64'd0);
    check("t2_st_mem",     64'(mem[10'h104]), 64'h12345678);
    run_txn(1'b1, 32'h104, 32'h0, 1'b0, 10);
    check("t2_ld_vld_cyc", 64'(t_vld), 64'd3);
    check("t2_ld_ddata",   64'(t_data), 64'h12345678);
    check("t2_ld_derr",    64'(t_err), 64'd0);

    // 3: both requesting, pointer favours D after reset
    do_reset();
    ng = 0; nv = 0;
    bus.IAddr = 32'h100; bus.DAddr = 32'h104; bus.DWEn = 1'b0;
    bus.IReq = 1'b1; bus.DReq = 1'b1;
    for (int k = 1; k <= 20 && nv < 4; k++) begin
      @(negedge clk);
      if (bus.DVld || bus.IVld) begin
        vk[nv] = k;
        nv++;
        if (ng < 4) begin
          if (bus.DVld) bus.DReq = 1'b1;
          else          bus.IReq = 1'b1;
        end
      end
      if (bus.DGnt || bus.IGnt) begin
        if (ng < 4) begin
          gseq[ng] = bus.DGnt ? 1 : 0;
          gk[ng]   = k;
        end
        ng++;
        if (bus.DGnt) bus.DReq = 1'b0;
        else          bus.IReq = 1'b0;
      end
    end
    bus.IReq = 1'b0; bus.DReq = 1'b0;
    check("t3_ngnt", 64'(ng), 64'd4);
    check("t3_nvld", 64'(nv), 64'd4);
    if (ng == 4 && nv == 4)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3_owner%0d", i), 64'(gseq[i]), 64'((i % 2 == 0) ? 1 : 0));
        check($sformatf("t3_gnt_cyc%0d", i), 64'(gk[i]), 64'(1 + 3 * i));
        check($sformatf("t3_vld_cyc%0d", i), 64'(vk[i]), 64'(3 + 3 * i));
      end
    @(negedge clk);

    // 4: memory silent, watchdog aborts the load
    force_nvld = 1'b1;
    run_txn(1'b1, 32'h200, 32'h0, 1'b0, 30);
    check("t4_gnt_cyc",  64'(t_gnt), 64'd1);
    check("t4_vld_cyc",  64'(t_vld), 64'd18);
    check("t4_derr",     64'(t_err), 64'd1);
    check("t4_ddata",    64'(t_data), 64'd0);
    check("t4_busy",     64'(bus.Busy), 64'd0);
    force_nvld = 1'b0;
    run_txn(1'b0, 32'h100, 32'h0, 1'b0, 10);
    check("t4_after_vld", 64'(t_vld), 64'd3);
    check("t4_after_dat", 64'(t_data), 64'hDEADBEEF);
    check("t4_after_err", 64'(t_err), 64'd0);

    // 5: async reset while parked in WAIT
    force_nvld = 1'b1;
    bus.IAddr = 32'h104; bus.IReq = 1'b1;
    @(negedge clk);
    bus.IReq = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_busy_pre",  64'(bus.Busy), 64'd1);
    check("t5_raddr_pre", 64'(bus.RAddr), 64'h104);
    rstn = 1'b0;
    #1;
    check("t5_rst_ctl", 64'({bus.IGnt, bus.IVld, bus.IErr, bus.DGnt, bus.DVld, bus.DErr,
                             bus.RRdy, bus.RWEn, bus.Busy}), 64'd0);
    check("t5_rst_addr", 64'(bus.RAddr), 64'd0);
    check("t5_rst_data", 64'({bus.IData, bus.DData}), 64'd0);
    @(negedge clk);
    force_nvld = 1'b0;
    rstn = 1'b1;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.IVld | bus.DVld | bus.IGnt | bus.DGnt | bus.Busy) quiet++;
    end
    check("t5_no_stale", 64'(quiet), 64'd0);
    run_txn(1'b0, 32'h100, 32'h0, 1'b0, 10);
    check("t5_new_vld",  64'(t_vld), 64'd3);
    check("t5_new_data", 64'(t_data), 64'hDEADBEEF);

    // 6: spurious response while idle
    @(negedge clk);
    inj_rvld = 1'b1;
    @(negedge clk);
    inj_rvld = 1'b0;
    quiet = 0;
    repeat (3) begin
      if (bus.IVld | bus.DVld | bus.Busy) quiet++;
      @(negedge clk);
    end
    check("t6_ignored", 64'(quiet), 64'd0);

    check("excl_pulses", 64'(both_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
